// File: rtl/if_fetch_stage_pkg.sv
// Shared constants, FSM state type and address helper for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned INST_LEN = 32;
  localparam int unsigned PC_INC   = 4;
  localparam logic [INST_LEN-1:0] NOP_INST = '0;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } if_state_e;

  function automatic logic [INST_LEN-1:0] word_align(input logic [INST_LEN-1:0] addr);
    return {addr[INST_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Single-outstanding request/acknowledge instruction-memory port.
interface if_fetch_stage_if
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned W = INST_LEN
);

  logic         o_imem_req;
  logic [W-1:0] o_imem_addr;
  logic         i_imem_ack;
  logic [W-1:0] i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ack,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ack,
    output i_imem_rdata
  );

endinterface

// File: rtl/if_fetch_stage_hold_buffer.sv
// Load-enable instruction register with valid flag; keeps a fetched word while the pipe is frozen.
module if_fetch_stage_hold_buffer #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem port and presents {PC+4, instruction} to IF/ID.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned            P_INST_LEN = INST_LEN,
  parameter logic [P_INST_LEN-1:0]  P_RESET_PC = '0
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_freeze,
  input  logic                  i_branch_taken,
  input  logic [P_INST_LEN-1:0] i_branch_target,
  if_fetch_stage_if.master      imem,
  output logic [P_INST_LEN-1:0] o_PC_out,
  output logic [P_INST_LEN-1:0] o_instruction_out,
  output logic                  o_inst_valid
);

  if_state_e             state_q, state_d;
  logic [P_INST_LEN-1:0] pc_q, pc_d;
  logic [P_INST_LEN-1:0] redir_q, redir_d;

  logic [P_INST_LEN-1:0] pc_inc;
  logic [P_INST_LEN-1:0] tgt;
  logic                  req;
  logic                  hold_load, hold_clear, hold_valid;
  logic [P_INST_LEN-1:0] hold_data;

  assign pc_inc = pc_q + P_INST_LEN'(PC_INC);
  assign tgt    = word_align(i_branch_target);

  if_fetch_stage_hold_buffer #(
    .W(P_INST_LEN)
  ) u_hold (
    .clk_i  (i_sys_clk),
    .rst_i  (i_sys_rst),
    .load_i (hold_load),
    .clear_i(hold_clear),
    .data_i (imem.i_imem_rdata),
    .data_o (hold_data),
    .valid_o(hold_valid)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= S_RST;
      pc_q    <= P_RESET_PC;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  // req depends on state only, so freeze never reaches the memory port combinationally
  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    redir_d           = redir_q;
    req               = 1'b0;
    o_instruction_out = NOP_INST;
    o_inst_valid      = 1'b0;
    hold_load         = 1'b0;
    hold_clear        = 1'b0;
    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        req = 1'b1;
        if (i_branch_taken) begin
          if (imem.i_imem_ack) begin
            pc_d = tgt;
          end else begin
            redir_d = tgt;
            state_d = S_DRAIN;
          end
        end else if (imem.i_imem_ack) begin
          o_instruction_out = imem.i_imem_rdata;
          o_inst_valid      = 1'b1;
          if (i_freeze) begin
            hold_load = 1'b1;
            state_d   = S_HOLD;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      S_HOLD: begin
        if (i_branch_taken) begin
          pc_d       = tgt;
          state_d    = S_FETCH;
          hold_clear = 1'b1;
        end else begin
          o_instruction_out = hold_data;
          o_inst_valid      = hold_valid;
          if (!i_freeze) begin
            pc_d       = pc_inc;
            state_d    = S_FETCH;
            hold_clear = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Squashed fetch must still complete; the newest redirect wins.
        req = 1'b1;
        if (i_branch_taken) redir_d = tgt;
        if (imem.i_imem_ack) begin
          pc_d    = i_branch_taken ? tgt : redir_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  assign imem.o_imem_req  = req;
  assign imem.o_imem_addr = pc_q;
  assign o_PC_out         = pc_inc;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter and drives a single-outstanding request/acknowledge instruction-memory port. It presents {PC+4, instruction} to the IF/ID register, inserting NOP bubbles while memory is slow. It holds a fetched instruction while the pipeline is frozen and redirects on taken branches, squashing any in-flight fetch.

Parameters:
P_RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
P_INST_LEN, `INST_LEN (32), instruction/address width

Ports:
i_sys_clk  input  1  system clock; all state updates on rising edge
i_sys_rst  input  1  synchronous, active-high reset
i_freeze  input  1  hazard-unit freeze; same signal drives IF/ID i_freeze
i_branch_taken  input  1  one-cycle redirect pulse from ID
i_branch_target  input  32  redirect address; bits [1:0] forced to 0 internally
o_imem_req  output  1  instruction-memory request
o_imem_addr  output  32  request word address (byte address, word aligned)
i_imem_ack  input  1  memory acknowledge; i_imem_rdata valid this cycle
i_imem_rdata  input  32  instruction word
o_PC_out  output  32  PC+4 of presented instruction (to IF/ID i_PC_in)
o_instruction_out  output  32  presented instruction, 32'h0000_0000 (NOP) when invalid
o_inst_valid  output  1  presented instruction is real (not a bubble)

Behaviour:
- Reset is synchronous, active-high. State goes to S_RST and r_pc to P_RESET_PC. Hold buffer, redirect register and o_imem_req go to 0; o_inst_valid = 0; o_instruction_out = 0; o_PC_out = P_RESET_PC+4.
- Reset during an outstanding request abandons it. An ack arriving in S_RST is ignored.
- Memory protocol: the request is held until ack, with address stable. There is at most one request outstanding. Ack may arrive the same cycle as req (zero-wait). Ack is ignored in S_RST and S_HOLD.
- States:
  - S_RST: req = 0. Next cycle goes to S_FETCH.
  - S_FETCH: req = 1, addr = r_pc.
    - No ack: output a bubble.
    - Ack and ~freeze: present rdata combinationally with valid = 1; r_pc <= r_pc+4; stay in S_FETCH. Back-to-back fetch gives 1 instruction/cycle with zero-wait memory.
    - Ack and freeze: present rdata (IF/ID ignores it); capture it in the hold buffer; go to S_HOLD.
  - S_HOLD: req = 0; present the hold buffer with valid = 1; o_PC_out = r_pc+4. When ~freeze, r_pc <= r_pc+4 and go to S_FETCH.
  - S_DRAIN: req = 1 with the old address; output a bubble. On ack, discard the data, r_pc <= redirect register, go to S_FETCH.
- Branch (i_branch_taken = 1) has priority over freeze and ack in every state except S_RST. Output that cycle is a bubble.
  - S_FETCH with ack, or S_HOLD: r_pc <= target; go to S_FETCH.
  - S_FETCH without ack: redirect register <= target; go to S_DRAIN.
  - S_DRAIN: redirect register <= the new target (latest wins). If ack arrives the same cycle, go straight to S_FETCH with the new target.
  - Branch in S_RST is ignored.
- Arithmetic: PC increment is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- Bubble: o_instruction_out = 0 and o_inst_valid = 0. o_PC_out still equals r_pc+4.
- No combinational path from i_freeze to o_imem_req. Paths from ack/rdata/branch to the outputs are combinational.

Decomposition:
- defines.v (shared) gains: `NOP_INST (32'h0), `IF_ST_* state encodings (2-bit), `PC_INC (4). It reuses `INST_LEN and `WORD_LEN.
- One natural sub-module: if_hold_buffer, a 32-bit load-enable register with valid flag, used for S_HOLD.
- The PC and FSM stay in the top module.

Test Plan:
- Reset with P_RESET_PC = 0x100 and zero-wait memory -> first req addr 0x100 two cycles after reset release. Then 0x104 and 0x108 on consecutive cycles, o_PC_out 0x104/0x108/0x10C, valid every cycle.
- Memory acks after 3 cycles -> two bubble cycles (instruction 0, valid 0), then valid instruction. Address stays 0x100 throughout the wait.
- Ack with freeze high for 4 cycles -> S_HOLD. Instruction 0xAABBCCDD presented steadily, req = 0. On freeze drop, next req at PC+4.
- Branch to 0x200 while a fetch of 0x110 is outstanding (no ack) -> req stays at 0x110 until ack. Data discarded, valid 0. Next req is 0x200.
- Branch to 0x300 in the same cycle as an ack for 0x120 with freeze high -> ack data dropped, valid 0, next req 0x300. Also: PC at 0xFFFF_FFFC with zero-wait memory -> next addr 0x0000_0000.
- Reset asserted in S_DRAIN -> next cycle req = 0, PC = P_RESET_PC, late ack ignored.
